pw_arbiter: RTL and testbench
=============================

Name: pw_arbiter

Overview:
- Shares the single page-table walker among NUM_RQ requesters: instruction-fetch TLB, load AGU and store AGU.
- Each requester re-presents its request every cycle until it sees OUT_busy with its own ID on OUT_busyRqID, then waits for a result tagged with that ID.
- The block latches one request, forwards it to the walker, tracks the walk to completion and broadcasts the tagged result.
- Arbitration is round-robin, so no requester starves.

Parameters:
- NUM_RQ, 3, number of requesters; ID i = port slot i.
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_RQ.
- PPN_W, 22, width of the Sv32 root PPN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- IN_reqValid  in  NUM_RQ  per-requester walk request
- IN_reqAddr  in  NUM_RQ*32  per-requester virtual address; slot i at [32*i+:32]
- IN_reqRootPPN  in  NUM_RQ*PPN_W  per-requester root PPN
- OUT_busy  out  1  walk slot occupied (accepted request in flight)
- OUT_busyRqID  out  ID_W  ID of the accepted requester; valid while OUT_busy
- OUT_walkValid  out  1  request to walker
- OUT_walkAddr  out  32  latched virtual address
- OUT_walkRootPPN  out  PPN_W  latched root PPN
- IN_walkReady  in  1  walker accepts request this cycle
- IN_resValid  in  1  walker result strobe
- IN_resPPN  in  20  leaf PPN
- IN_resRWX  in  3  leaf permission bits
- IN_resUser  in  1  leaf U bit
- IN_resIsSuper  in  1  megapage leaf
- IN_resPageFault  in  1  page fault during walk
- IN_resAccessFault  in  1  access fault during walk
- OUT_res*  out  same widths as IN_res*  registered copy of the result
- OUT_resRqID  out  ID_W  ID the result belongs to

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, rrPtr=0.
  - OUT_busy=0, OUT_walkValid=0, OUT_resValid=0.
  - Other outputs are don't-care but driven to 0.
  - Reset mid-walk abandons the walk; a later IN_resValid is ignored.
- State machine IDLE -> ISSUE -> WAIT -> IDLE:
  - IDLE, any IN_reqValid:
    - Grant g = first set bit searching from rrPtr upward, wrapping modulo NUM_RQ.
    - Latch addr/rootPPN of g; busyID<=g; rrPtr<=(g+1) mod NUM_RQ (wrap at NUM_RQ-1 -> 0); state<=ISSUE.
  - ISSUE:
    - OUT_busy=1, OUT_busyRqID=g, OUT_walkValid=1 with the latched fields.
    - On IN_walkReady: state<=WAIT.
    - Latched fields stay stable until accepted, even if the requester drops valid.
  - WAIT:
    - OUT_busy=1, OUT_walkValid=0.
    - On IN_resValid: register all result fields into OUT_res*, OUT_resRqID<=g, OUT_resValid<=1 for exactly one cycle.
    - Same edge: state<=IDLE, OUT_busy<=0.
- Latency:
  - Request to OUT_busy/OUT_walkValid: 1 cycle.
  - IN_resValid to OUT_resValid: 1 cycle.
  - A new grant can be sampled in the cycle OUT_resValid is high, so OUT_busy rises again the cycle after.
- OUT_busy, OUT_busyRqID, OUT_walkValid are registered (state-decoded from flops); no combinational path from IN_req* to any output.
- IN_resValid in IDLE or ISSUE is spurious: ignored, no OUT_resValid.
- IN_walkReady outside ISSUE is ignored.
- Requests arriving while not IDLE are not queued; requesters keep retrying.
- With all NUM_RQ requesting continuously, grants rotate 0,1,2,0,...
- Fairness bound: a continuously requesting requester is granted within NUM_RQ grants.

Decomposition:
- Shared package:
  - Exists in codebase: PageWalk_Req and PageWalk_Res structs.
  - New: PW_RQ_IFETCH=0, PW_RQ_LOAD=1, PW_RQ_STORE=2 constants, replacing hard-coded RQ_ID parameters at instantiation sites.
  - New: PwArbState enum (IDLE, ISSUE, WAIT).
- Sub-module rr_pick (NUM_RQ):
  - Combinational round-robin priority select.
  - Inputs: request vector, rrPtr. Outputs: one-hot grant and grant index.
  - Reusable for other shared-port arbiters.

Test Plan:
- Single request: IN_reqValid=3'b010, addr 0x8000_1234, IN_walkReady=1. Expect OUT_busy=1, OUT_busyRqID=1, OUT_walkAddr=0x8000_1234 next cycle. Inject IN_resValid with PPN 0x12345 two cycles later; expect OUT_resValid one cycle later, OUT_resRqID=1, OUT_resPPN=0x12345, OUT_busy=0 on that same cycle.
- All three requesting continuously, walker replies 3 cycles after accept: grant order 0,1,2,0,1,2. rrPtr wraps 2->0.
- Backpressure: IN_walkReady=0 for 5 cycles while requester 2 drops valid after cycle 1. Expect OUT_walkValid held for 5 cycles with unchanged addr/rootPPN, then acceptance; result tagged 2.
- Spurious IN_resValid in IDLE and during ISSUE: no OUT_resValid, no state change.
- Reset mid-walk: rst=0 in WAIT for 1 cycle. Expect all valid/busy outputs 0 and rrPtr=0; a later IN_resValid is ignored; next request from 1 is granted normally.
- Back-to-back: requester 0 asserts in the cycle OUT_resValid (for 2) is high. Expect OUT_busy=1 with ID 0 the following cycle.

Source files
------------

// File: rtl/pw_arbiter_pkg.sv
// Shared page-walk types: walker request/result records, requester IDs
// and the walk-slot arbiter state encoding.
package pw_arbiter_pkg;

    localparam int PW_PPN_W = 22;

    // Fixed requester slots on the shared walker port
    localparam int PW_RQ_IFETCH = 0;
    localparam int PW_RQ_LOAD   = 1;
    localparam int PW_RQ_STORE  = 2;

    typedef struct packed {
        logic [31:0]         addr;
        logic [PW_PPN_W-1:0] rootPPN;
    } PageWalk_Req;

    typedef struct packed {
        logic [19:0] ppn;
        logic [2:0]  rwx;
        logic        user;
        logic        isSuper;
        logic        pageFault;
        logic        accessFault;
    } PageWalk_Res;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } PwArbState;

endpackage

// File: rtl/pw_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or above ptr,
// wrapping modulo NUM_RQ. Reusable for any shared-port arbiter.
module pw_arbiter_rr_pick #(
    parameter int NUM_RQ = 3,
    parameter int ID_W   = 2
) (
    input  logic [NUM_RQ-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [NUM_RQ-1:0] gnt,
    output logic [ID_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    int slot;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        slot    = 0;
        for (int k = 0; k < NUM_RQ; k++) begin
            slot = int'(ptr) + k;
            if (slot >= NUM_RQ) slot = slot - NUM_RQ;
            if (!gnt_any && req[slot]) begin
                gnt[slot] = 1'b1;
                gnt_idx   = ID_W'(slot);
                gnt_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pw_arbiter.sv
// Shares one page-table walker among NUM_RQ requesters: round-robin grant,
// latched request issue, and a one-cycle tagged result broadcast.
module pw_arbiter
    import pw_arbiter_pkg::*;
#(
    parameter int NUM_RQ = 3,
    parameter int ID_W   = 2,
    parameter int PPN_W  = 22
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [NUM_RQ-1:0]       IN_reqValid,
    input  logic [NUM_RQ*32-1:0]    IN_reqAddr,
    input  logic [NUM_RQ*PPN_W-1:0] IN_reqRootPPN,

    output logic                    OUT_busy,
    output logic [ID_W-1:0]         OUT_busyRqID,

    output logic                    OUT_walkValid,
    output logic [31:0]             OUT_walkAddr,
    output logic [PPN_W-1:0]        OUT_walkRootPPN,
    input  logic                    IN_walkReady,

    input  logic                    IN_resValid,
    input  logic [19:0]             IN_resPPN,
    input  logic [2:0]              IN_resRWX,
    input  logic                    IN_resUser,
    input  logic                    IN_resIsSuper,
    input  logic                    IN_resPageFault,
    input  logic                    IN_resAccessFault,

    output logic                    OUT_resValid,
    output logic [19:0]             OUT_resPPN,
    output logic [2:0]              OUT_resRWX,
    output logic                    OUT_resUser,
    output logic                    OUT_resIsSuper,
    output logic                    OUT_resPageFault,
    output logic                    OUT_resAccessFault,
    output logic [ID_W-1:0]         OUT_resRqID
);

    if ((2 ** ID_W) < NUM_RQ) begin : g_bad_id_w
        $error("ID_W too narrow for NUM_RQ");
    end

    PwArbState          state_p0, state_nxt;
    logic [ID_W-1:0]    rr_ptr_p0;
    logic [ID_W-1:0]    rr_ptr_nxt;

    logic [NUM_RQ-1:0]  pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;

    logic [31:0]        sel_addr;
    logic [PPN_W-1:0]   sel_ppn;

    logic [ID_W-1:0]    busy_id_p1;
    logic [31:0]        walk_addr_p1;
    logic [PPN_W-1:0]   walk_ppn_p1;

    PageWalk_Res        res_p2;
    logic [ID_W-1:0]    res_id_p2;
    logic               vld_p2;

    pw_arbiter_rr_pick #(
        .NUM_RQ (NUM_RQ),
        .ID_W   (ID_W)
    ) u_pick (
        .req     (IN_reqValid),
        .ptr     (rr_ptr_p0),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // One-hot steering of the granted requester's fields
    always_comb begin
        sel_addr = '0;
        sel_ppn  = '0;
        for (int i = 0; i < NUM_RQ; i++) begin
            if (pick_gnt[i]) begin
                sel_addr = IN_reqAddr[32*i +: 32];
                sel_ppn  = IN_reqRootPPN[PPN_W*i +: PPN_W];
            end
        end
    end

    assign rr_ptr_nxt = (pick_idx == ID_W'(NUM_RQ - 1)) ? '0 : pick_idx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) state_p0 <= IDLE;
        else      state_p0 <= state_nxt;
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE:    if (pick_any)     state_nxt = ISSUE;
            ISSUE:   if (IN_walkReady) state_nxt = WAIT;
            WAIT:    if (IN_resValid)  state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // p1: grant capture -- request fields frozen until the walker accepts
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_p0    <= '0;
            busy_id_p1   <= '0;
            walk_addr_p1 <= '0;
            walk_ppn_p1  <= '0;
        end else if (state_p0 == IDLE && pick_any) begin
            rr_ptr_p0    <= rr_ptr_nxt;
            busy_id_p1   <= pick_idx;
            walk_addr_p1 <= sel_addr;
            walk_ppn_p1  <= sel_ppn;
        end
    end

    // p2: result capture, strobed for exactly one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_p2    <= '0;
            res_id_p2 <= '0;
            vld_p2    <= 1'b0;
        end else begin
            vld_p2 <= 1'b0;
            if (state_p0 == WAIT && IN_resValid) begin
                res_p2    <= {IN_resPPN, IN_resRWX, IN_resUser, IN_resIsSuper,
                              IN_resPageFault, IN_resAccessFault};
                res_id_p2 <= busy_id_p1;
                vld_p2    <= 1'b1;
            end
        end
    end

    assign OUT_busy        = (state_p0 != IDLE);
    assign OUT_busyRqID    = busy_id_p1;
    assign OUT_walkValid   = (state_p0 == ISSUE);
    assign OUT_walkAddr    = walk_addr_p1;
    assign OUT_walkRootPPN = walk_ppn_p1;

    assign OUT_resValid       = vld_p2;
    assign OUT_resPPN         = res_p2.ppn;
    assign OUT_resRWX         = res_p2.rwx;
    assign OUT_resUser        = res_p2.user;
    assign OUT_resIsSuper     = res_p2.isSuper;
    assign OUT_resPageFault   = res_p2.pageFault;
    assign OUT_resAccessFault = res_p2.accessFault;
    assign OUT_resRqID        = res_id_p2;

endmodule

// File: tb/tb_pw_arbiter.sv
// Directed bench for pw_arbiter: grant order, latching, backpressure,
// spurious results, reset mid-walk and back-to-back grants.
module tb_pw_arbiter;
    import pw_arbiter_pkg::*;

    localparam int NUM_RQ = 3;
    localparam int ID_W   = 2;
    localparam int PPN_W  = 22;

    logic                    clk;
    logic                    rst;
    logic [NUM_RQ-1:0]       req_valid;
    logic [NUM_RQ*32-1:0]    req_addr;
    logic [NUM_RQ*PPN_W-1:0] req_ppn;
    logic                    busy;
    logic [ID_W-1:0]         busy_id;
    logic                    walk_valid;
    logic [31:0]             walk_addr;
    logic [PPN_W-1:0]        walk_ppn;
    logic                    walk_ready;
    logic                    res_valid;
    logic [19:0]             res_ppn;
    logic [2:0]              res_rwx;
    logic                    res_user, res_super, res_pf, res_af;
    logic                    o_res_valid;
    logic [19:0]             o_res_ppn;
    logic [2:0]              o_res_rwx;
    logic                    o_res_user, o_res_super, o_res_pf, o_res_af;
    logic [ID_W-1:0]         o_res_id;

    int checks = 0;
    int errors = 0;

    logic [31:0] addr_tab [NUM_RQ];

    pw_arbiter #(.NUM_RQ(NUM_RQ), .ID_W(ID_W), .PPN_W(PPN_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .IN_reqValid        (req_valid),
        .IN_reqAddr         (req_addr),
        .IN_reqRootPPN      (req_ppn),
        .OUT_busy           (busy),
        .OUT_busyRqID       (busy_id),
        .OUT_walkValid      (walk_valid),
        .OUT_walkAddr       (walk_addr),
        .OUT_walkRootPPN    (walk_ppn),
        .IN_walkReady       (walk_ready),
        .IN_resValid        (res_valid),
        .IN_resPPN          (res_ppn),
        .IN_resRWX          (res_rwx),
        .IN_resUser         (res_user),
        .IN_resIsSuper      (res_super),
        .IN_resPageFault    (res_pf),
        .IN_resAccessFault  (res_af),
        .OUT_resValid       (o_res_valid),
        .OUT_resPPN         (o_res_ppn),
        .OUT_resRWX         (o_res_rwx),
        .OUT_resUser        (o_res_user),
        .OUT_resIsSuper     (o_res_super),
        .OUT_resPageFault   (o_res_pf),
        .OUT_resAccessFault (o_res_af),
        .OUT_resRqID        (o_res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input logic [31:0] a, input logic [PPN_W-1:0] p);
        req_addr[32*s +: 32]       = a;
        req_ppn[PPN_W*s +: PPN_W]  = p;
    endtask

    task automatic wait_walk();
        int n;
        n = 0;
        while (!walk_valid && n < 20) begin
            tick();
            n++;
        end
        check_val("walk_valid_wait", walk_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = '0; req_addr = '0; req_ppn = '0;
        walk_ready = 1'b0; res_valid = 1'b0; res_ppn = '0; res_rwx = '0;
        res_user = 1'b0; res_super = 1'b0; res_pf = 1'b0; res_af = 1'b0;
        tick(); tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_walk_valid", walk_valid, 0);
        check_val("rst_res_valid", o_res_valid, 0);
        check_val("rst_busy_id", busy_id, 0);
        rst = 1'b1;

        // Single request from the load port
        set_slot(PW_RQ_LOAD, 32'h8000_1234, 22'h2ABCD);
        req_valid = 3'b010; walk_ready = 1'b1;
        tick();
        check_val("single_busy", busy, 1);
        check_val("single_id", busy_id, 1);
        check_val("single_wvalid", walk_valid, 1);
        check_val("single_addr", walk_addr, 32'h8000_1234);
        check_val("single_root", walk_ppn, 22'h2ABCD);
        req_valid = '0;
        tick();
        check_val("single_wait_wvalid", walk_valid, 0);
        check_val("single_wait_busy", busy, 1);
        tick();
        res_valid = 1'b1; res_ppn = 20'h12345; res_rwx = 3'b101;
        tick();
        res_valid = 1'b0;
        check_val("single_res_valid", o_res_valid, 1);
        check_val("single_res_id", o_res_id, 1);
        check_val("single_res_ppn", o_res_ppn, 20'h12345);
        check_val("single_res_rwx", o_res_rwx, 3'b101);
        check_val("single_res_busy", busy, 0);
        tick();
        check_val("single_res_drop", o_res_valid, 0);

        // All three requesting: grants rotate 0,1,2,0,1,2 from a fresh pointer
        rst = 1'b0; tick(); rst = 1'b1;
        addr_tab[0] = 32'h1000_0000; addr_tab[1] = 32'h2000_0004; addr_tab[2] = 32'h3000_0008;
        for (int s = 0; s < NUM_RQ; s++) set_slot(s, addr_tab[s], PPN_W'(s + 22'h100));
        req_valid = 3'b111; walk_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            wait_walk();
            check_val($sformatf("rot_id_%0d", g), busy_id, g % 3);
            check_val($sformatf("rot_addr_%0d", g), walk_addr, addr_tab[g % 3]);
            tick(); tick(); tick();
            res_valid = 1'b1; res_ppn = 20'(20'h100 + g);
            tick();
            res_valid = 1'b0;
            check_val($sformatf("rot_res_valid_%0d", g), o_res_valid, 1);
            check_val($sformatf("rot_res_id_%0d", g), o_res_id, g % 3);
            check_val($sformatf("rot_res_ppn_%0d", g), o_res_ppn, 20'h100 + g);
        end
        req_valid = '0;
        tick();
        check_val("rot_idle", busy, 0);

        // Backpressure: store port drops valid, latched fields must hold
        set_slot(PW_RQ_STORE, 32'hC0DE_0000, 22'h155555);
        walk_ready = 1'b0; req_valid = 3'b100;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("bp_wvalid_%0d", i), walk_valid, 1);
            check_val($sformatf("bp_addr_%0d", i), walk_addr, 32'hC0DE_0000);
            check_val($sformatf("bp_root_%0d", i), walk_ppn, 22'h155555);
            if (i == 0) begin
                req_valid = '0;
                set_slot(PW_RQ_STORE, 32'hDEAD_BEEF, 22'h0);
            end
            if (i < 4) tick();
        end
        walk_ready = 1'b1;
        tick();
        walk_ready = 1'b0;
        check_val("bp_accept_wvalid", walk_valid, 0);
        check_val("bp_accept_busy", busy, 1);
        check_val("bp_accept_id", busy_id, 2);
        res_valid = 1'b1; res_ppn = 20'hABCDE; res_rwx = 3'b011;
        res_user = 1'b1; res_super = 1'b1; res_pf = 1'b1; res_af = 1'b0;
        tick();
        res_valid = 1'b0;
        check_val("bp_res_valid", o_res_valid, 1);
        check_val("bp_res_id", o_res_id, 2);
        check_val("bp_res_flags", {o_res_rwx, o_res_user, o_res_super, o_res_pf, o_res_af}, 7'b011_1110);
        check_val("bp_res_ppn", o_res_ppn, 20'hABCDE);
        res_user = 1'b0; res_super = 1'b0; res_pf = 1'b0; res_af = 1'b1;
        tick();

        // Spurious results in IDLE and ISSUE
        res_valid = 1'b1;
        tick();
        check_val("spur_idle_res", o_res_valid, 0);
        check_val("spur_idle_busy", busy, 0);
        res_valid = 1'b0;
        set_slot(PW_RQ_IFETCH, 32'h0000_4000, 22'h00ABC);
        req_valid = 3'b001;
        tick();
        check_val("spur_issue_id", busy_id, 0);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0; req_valid = '0;
        check_val("spur_issue_res", o_res_valid, 0);
        check_val("spur_issue_wvalid", walk_valid, 1);
        walk_ready = 1'b1;
        tick();
        check_val("spur_wait_busy", busy, 1);

        // Reset while waiting for the walker
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_wvalid", walk_valid, 0);
        check_val("mid_rst_res", o_res_valid, 0);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        check_val("mid_rst_late_res", o_res_valid, 0);
        check_val("mid_rst_late_busy", busy, 0);
        req_valid = 3'b101;
        tick();
        req_valid = '0;
        check_val("mid_rst_ptr_id", busy_id, 0);
        tick();
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        check_val("mid_rst_res_id", o_res_id, 0);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        check_val("post_rst_busy", busy, 1);
        check_val("post_rst_id", busy_id, 1);
        tick();
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        check_val("post_rst_res_id", o_res_id, 1);

        // Back-to-back: new grant sampled while the previous result is strobed
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        check_val("b2b_first_id", busy_id, 2);
        tick();
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        check_val("b2b_res_valid", o_res_valid, 1);
        check_val("b2b_res_id", o_res_id, 2);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        check_val("b2b_busy", busy, 1);
        check_val("b2b_id", busy_id, 0);
        check_val("b2b_wvalid", walk_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
